// File: rtl/wb_port_arbiter_pkg.sv
// Shared register-file constants and types for the WB write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } ll_entry_t;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_PIPE,
    PORT_FIFO
  } port_src_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// Synchronous FIFO buffering LLU results ({rd,data}) until the write port is free.
module wb_arb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  ll_entry_t push_entry_i,
  input  logic      pop_i,
  output ll_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // Extra pointer MSB distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  ll_entry_t   mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB wins, LLU results queue and drain on idle cycles.
// Optional forced drain after starvation is enabled by defining WB_ARB_STARVE_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned LL_FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  input  logic        i_ll_issue,
  input  logic [4:0]  i_ll_issue_rd,
  input  logic        i_ll_valid,
  input  logic [4:0]  i_ll_rd,
  input  logic [31:0] i_ll_data,
  output logic        o_ll_ready,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_qd,
  output logic        o_hazard,
  output logic        o_pipe_stall,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_wa,
  output logic [31:0] o_rf_wd
);

  if ((LL_FIFO_DEPTH < 2) || ((LL_FIFO_DEPTH & (LL_FIFO_DEPTH - 1)) != 0) || (STARVE_LIMIT == 0))
  begin : g_bad_cfg
    $error("wb_port_arbiter: LL_FIFO_DEPTH must be a power of 2 >= 2 and STARVE_LIMIT > 0");
  end

  logic      fifo_full, fifo_empty;
  logic      push, pop, pipe_win;
  ll_entry_t head;
  port_src_e src;
  logic [31:0] busy_q, busy_d;

  wb_arb_fifo #(.DEPTH(LL_FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i ('{rd: i_ll_rd, data: i_ll_data}),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  assign o_ll_ready = ~reset & ~fifo_full;
  assign push       = i_ll_valid & o_ll_ready;
  assign pipe_win   = i_wb_we & (i_wb_rd != REG_ZERO) & ~o_pipe_stall;

`ifdef WB_ARB_STARVE_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] starve_q, starve_d;

  // Saturates at LIMIT; the forced pop on that cycle clears it.
  always_comb begin
    starve_d = starve_q;
    if (pop)
      starve_d = '0;
    else if (!fifo_empty && pipe_win && (starve_q != LIMIT))
      starve_d = starve_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  assign o_pipe_stall = ~reset & (starve_q == LIMIT);
`else
  assign o_pipe_stall = 1'b0;
`endif

  always_comb begin
    src = PORT_IDLE;
    if (pipe_win)         src = PORT_PIPE;
    else if (!fifo_empty) src = PORT_FIFO;
  end

  assign pop = ~reset & (src == PORT_FIFO);

  always_comb begin
    o_rf_we = 1'b0;
    o_rf_wa = '0;
    o_rf_wd = '0;
    if (!reset) begin
      unique case (src)
        PORT_PIPE: begin
          o_rf_we = 1'b1;
          o_rf_wa = i_wb_rd;
          o_rf_wd = i_wb_data;
        end
        PORT_FIFO: begin
          o_rf_we = (head.rd != REG_ZERO);
          o_rf_wa = head.rd;
          o_rf_wd = head.data;
        end
        default: ;
      endcase
    end
  end

  // Clear applied before set so a same-register issue on the drain cycle keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (pop && (head.rd != REG_ZERO))
      busy_d[head.rd] = 1'b0;
    if (i_ll_issue && (i_ll_issue_rd != REG_ZERO))
      busy_d[i_ll_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign o_hazard = ~reset & (busy_q[i_rs] | busy_q[i_rt] | busy_q[i_qd]);

endmodule
